// File: rtl/alu_pkg.sv
// Shared ALU function codes and multiply sequencer FSM state type.
// Imported by the multiply sequencer and by anything driving the team ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_SLL = 2'b10,
    ALU_OR  = 2'b11
  } alu_funct_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } mul_state_e;

  localparam int unsigned MUL_CNT_W = 6;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows an external ALU for add and sll.
// Ports:
//   clk, rst                    clock, sync active-high reset
//   Start, Multiplicand,
//   Multiplier                  request + operands (sampled when idle)
//   Busy, Done, Product         status and low 32 bits of A*B
//   ALU_src_1/2, ALU_shamt,
//   ALU_funct                   registered drive to the external ALU
//   ALU_result                  combinational result from the ALU
// Build option: MUL_EARLY_EXIT_EN finishes as soon as the remaining
// multiplier bits are all zero (after at least one add/shift pair).
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MUL_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product,
  output logic [31:0] ALU_src_1,
  output logic [31:0] ALU_src_2,
  output logic [4:0]  ALU_shamt,
  output logic [1:0]  ALU_funct,
  input  logic [31:0] ALU_result
);

  mul_state_e           state_q;
  alu_funct_e           funct_q;
  logic [31:0]          acc_q;
  logic [31:0]          mcand_q;
  logic [31:0]          mplr_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic [31:0]          product_q;
  logic [31:0]          src1_q;
  logic [31:0]          src2_q;
  logic [4:0]           shamt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [MUL_CNT_W-1:0] cnt_d;
  logic [31:0]          mplr_d;
  logic                 last;

  assign cnt_d  = cnt_q + 1'b1;
  assign mplr_d = mplr_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (cnt_d == MUL_CNT_W'(MUL_BITS)) || (mplr_d == '0);
`else
  assign last = (cnt_d == MUL_CNT_W'(MUL_BITS));
`endif

  // ALU drive is registered, so each transition loads the operands
  // the ALU must see during the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      funct_q   <= ALU_ADD;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      shamt_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            mcand_q <= Multiplicand;
            mplr_q  <= Multiplier;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            src1_q  <= '0;
            src2_q  <= Multiplicand;
            shamt_q <= '0;
            funct_q <= ALU_ADD;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (mplr_q[0]) acc_q <= ALU_result;
          src1_q  <= mcand_q;
          src2_q  <= '0;
          shamt_q <= 5'd1;
          funct_q <= ALU_SLL;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          mcand_q <= ALU_result;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_d;
          shamt_q <= '0;
          funct_q <= ALU_ADD;
          if (last) begin
            product_q <= acc_q;
            done_q    <= 1'b1;
            src1_q    <= '0;
            src2_q    <= '0;
            state_q   <= S_DONE;
          end else begin
            // acc is stable here; the shifted mcand is on ALU_result
            src1_q  <= acc_q;
            src2_q  <= ALU_result;
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Product   = product_q;
  assign ALU_src_1 = src1_q;
  assign ALU_src_2 = src2_q;
  assign ALU_shamt = shamt_q;
  assign ALU_funct = funct_q;

endmodule

// File: doc/alu_mul_sequencer.md
ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 SHALL have parameter MUL_BITS, default 32: number of multiplier bits iterated, legal range 1..32.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have Start  input  1  request a multiply; sampled only when Busy=0.
REQ-005 SHALL have Multiplicand  input  32  operand A; latched on accepted Start.
REQ-006 SHALL have Multiplier  input  32  operand B; latched on accepted Start.
REQ-007 SHALL have Busy  output  1  high from the cycle after acceptance through the Done cycle.
REQ-008 SHALL have Done  output  1  one-cycle pulse; Product is valid in this cycle.
REQ-009 SHALL have Product  output  32  low 32 bits of A*B; held until the next accepted Start.
REQ-010 SHALL have ALU_src_1, ALU_src_2  output  32 each  operands driven to the external ALU.
REQ-011 SHALL have ALU_shamt  output  5 and ALU_funct  output  2  drive the external ALU's shift amount and function inputs.
REQ-012 SHALL have ALU_result  input  32  combinational result returned by the external ALU.

Function
REQ-013 SHALL implement the FSM states IDLE, ADD, SHIFT and DONE.
REQ-014 IDLE: Start=1 SHALL latch the operands, clear acc and the counter, and go to ADD; Start=0 SHALL stay in IDLE.
REQ-015 ADD: SHALL drive funct=00 (add), src_1=acc, src_2=mcand and shamt=0; if mplr[0]=1, acc<=ALU_result, else acc unchanged; next state SHIFT.
REQ-016 SHIFT: SHALL drive funct=10 (sll), src_1=mcand, src_2=0 and shamt=1; mcand<=ALU_result, mplr<=mplr>>1 (internal logical shift), count<=count+1.
REQ-017 SHIFT exit: SHALL go to DONE when count+1==MUL_BITS, else to ADD.
REQ-018 DONE: SHALL assert Done=1, Busy=1 and Product=acc; next state IDLE; Start in this cycle SHALL be ignored.
REQ-019 IDLE/DONE ALU drive: SHALL be src_1=0, src_2=0, shamt=0, funct=00.
REQ-020 Latency (fixed mode): Start accepted at edge t SHALL give Done high in cycle t+2*MUL_BITS+1; MUL_BITS=32 gives 65 cycles.
REQ-021 Arithmetic: SHALL be unsigned modulo 2^32; overflow is discarded silently; the low 32 bits equal the signed product.
REQ-022 Start while Busy=1 SHALL be ignored, with no effect on operands or state.
REQ-023 SHALL never drive funct 01 or 11.

Reset
REQ-024 rst=1 SHALL force IDLE, Busy=0, Done=0, Product=0, acc/mcand/mplr/count=0 and ALU drive to zeros, on the next edge from any state, including mid-operation.
REQ-025 rst SHALL take priority over Start in the same cycle.

Configuration
REQ-026 SHALL support macro MUL_EARLY_EXIT_EN.
- Defined: SHIFT goes to DONE when the shifted mplr==0 or count+1==MUL_BITS.
- Defined: minimum of one ADD/SHIFT pair, so Multiplier=0 gives Done at t+3.
- Undefined: fixed latency per REQ-020.
REQ-027 Product values SHALL be identical with and without MUL_EARLY_EXIT_EN.

Structure
REQ-028 Shared package alu_pkg SHALL hold the ALU function codes ALU_ADD=00, ALU_SUB=01, ALU_SLL=10 and ALU_OR=11, plus the FSM state type.
REQ-029 The ALU SHALL stay external; the block has no sub-modules, with the FSM, counter and operand registers flat in one module.

Verification
REQ-030 The bench SHALL instantiate the team ALU connected to the ALU_* ports and cover the following scenarios.
REQ-031 A=3, B=5, fixed mode -> Done in cycle t+65, Product=15, Busy high for 65 cycles.
REQ-032 A=0xFFFFFFFF, B=2 -> Product=0xFFFFFFFE; A=0x00010000, B=0x00010000 -> Product=0 (wrap).
REQ-033 Start pulsed at cycle t+10 during A=6, B=7 -> ignored, Product=42, and no second Done.
REQ-034 rst at cycle t+20 mid-operation -> next cycle IDLE, Busy=0, Product=0; a new Start with A=2, B=9 gives Product=18.
REQ-035 MUL_EARLY_EXIT_EN defined: A=7, B=1 -> Done at t+3, Product=7; A=5, B=0 -> Done at t+3, Product=0; A=1, B=0x80000000 -> Done at t+65.
REQ-036 Start held high continuously -> back-to-back operations, each accepted in the IDLE cycle after Done.
